// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch block.
package fetch_pkg;

  localparam int INSTR_BYTES  = 4;
  localparam int FETCH_ADDR_W = 10;
  localparam int FETCH_DATA_W = 32;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

  // Sequential fetch address; wraps naturally modulo 2**FETCH_ADDR_W.
  function automatic logic [FETCH_ADDR_W-1:0] next_pc(input logic [FETCH_ADDR_W-1:0] pc);
    return pc + FETCH_ADDR_W'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, instr} entries; flush beats push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               push_i,
  input  fetch_entry_t       data_i,
  input  logic               pop_i,
  output fetch_entry_t       data_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               empty_o,
  output logic               full_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only observed while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: drives the synchronous ROM, tracks one in-flight read,
// buffers returned words and hands {pc, instr} to decode over valid/ready.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_WIDTH = FETCH_ADDR_W,
  parameter int          DATA_WIDTH = FETCH_DATA_W,
  parameter int unsigned RESET_PC   = 0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  inflight_q, inflight_d;

  fetch_entry_t     push_entry, head_entry;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occupancy;
  logic             fifo_empty, fifo_full;
  logic             pop, push, issue;
  logic             unused_sig;

  assign unused_sig = ^{redirect_pc_i[1:0], fifo_full};

  assign pop  = valid_o && ready_i;
  assign push = inflight_q && !redirect_i;

  // Credit check: entries that will remain after this edge's pop, plus the read
  // still in flight, must leave room for the word we are about to request.
  assign occupancy = {1'b0, fifo_count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign issue     = !redirect_i && (occupancy < (CNT_W+1)'(FIFO_DEPTH));

  assign push_entry = '{pc: inflight_pc_q, instr: imem_rdata_i};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
    end else if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = next_pc(fetch_pc_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q    <= ADDR_WIDTH'(RESET_PC);
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign imem_addr_o = fetch_pc_q;
  assign valid_o     = !fifo_empty;
  assign instr_o     = fifo_empty ? '0 : head_entry.instr;
  assign pc_o        = fifo_empty ? '0 : head_entry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirects, wrap and async reset.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [9:0]  imem_addr_o;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i;
  logic [9:0]  redirect_pc_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [9:0]  pc_o;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_unit dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o)
  );

  always #5 clk_i = ~clk_i;

  // ROM: word i holds A000_0000 + i, data one clock after the address is sampled.
  always @(posedge clk_i) imem_rdata_i <= 32'hA000_0000 + 32'(imem_addr_o >> 2);

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [9:0] pc,
                           input logic [31:0] instr);
    check({tag, ".valid"}, 32'(valid_o), 32'(v));
    check({tag, ".pc"},    32'(pc_o),    32'(pc));
    check({tag, ".instr"}, instr_o,      instr);
  endtask

  task automatic check_addr(input string tag, input logic [9:0] addr);
    check({tag, ".addr"}, 32'(imem_addr_o), 32'(addr));
  endtask

  initial begin
    rst_ni = 1'b1; ready_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    #2 rst_ni = 1'b0;
    #1;
    check_out("rst", 1'b0, 10'h000, 32'h0);
    check_addr("rst", 10'h000);
    tick(); tick();
    rst_ni = 1'b1;

    // Stream with ready held high
    tick(); $display("E0 addr=%h valid=%b", imem_addr_o, valid_o);
    check_out("e0", 1'b0, 10'h000, 32'h0);
    check_addr("e0", 10'h004);
    tick(); $display("E1 pc=%h instr=%h", pc_o, instr_o);
    check_out("s0", 1'b1, 10'h000, 32'hA000_0000);
    check_addr("s0", 10'h008);
    tick(); check_out("s1", 1'b1, 10'h004, 32'hA000_0001);
    tick(); check_out("s2", 1'b1, 10'h008, 32'hA000_0002);

    // Redirect to 0x103 while pc 8 is being accepted and pc 12 is in flight
    redirect_i = 1'b1; redirect_pc_i = 10'h103;
    tick(); redirect_i = 1'b0;
    $display("redirect 0x103 valid=%b addr=%h", valid_o, imem_addr_o);
    check_out("rd0", 1'b0, 10'h000, 32'h0);
    check_addr("rd0", 10'h100);
    tick(); check_out("rd1", 1'b0, 10'h000, 32'h0);
    tick(); check_out("rd2", 1'b1, 10'h100, 32'hA000_0040);
    tick(); check_out("rd3", 1'b1, 10'h104, 32'hA000_0041);

    // Asynchronous reset between edges
    #2 rst_ni = 1'b0;
    #1;
    $display("async reset valid=%b addr=%h", valid_o, imem_addr_o);
    check_out("arst", 1'b0, 10'h000, 32'h0);
    check_addr("arst", 10'h000);
    tick();
    ready_i = 1'b0;
    rst_ni = 1'b1;

    // Restart from 0 with ready low: two entries buffered, then fetch stalls
    tick(); check_addr("b0", 10'h004);
    check_out("b0", 1'b0, 10'h000, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      $display("stall %0d pc=%h addr=%h", i, pc_o, imem_addr_o);
      check_out("bp", 1'b1, 10'h000, 32'hA000_0000);
      check_addr("bp", 10'h008);
    end
    ready_i = 1'b1;
    tick(); check_out("bq1", 1'b1, 10'h004, 32'hA000_0001);
    tick(); check_out("bq2", 1'b1, 10'h008, 32'hA000_0002);
    tick(); check_out("bq3", 1'b1, 10'h00C, 32'hA000_0003);

    // Fill the buffer with ready low, then redirect to 0x20
    ready_i = 1'b0;
    tick(); check_out("st", 1'b1, 10'h00C, 32'hA000_0003);
    check_addr("st", 10'h014);
    redirect_i = 1'b1; redirect_pc_i = 10'h020;
    tick(); redirect_i = 1'b0; ready_i = 1'b1;
    check_out("sr0", 1'b0, 10'h000, 32'h0);
    check_addr("sr0", 10'h020);
    tick(); check_out("sr1", 1'b0, 10'h000, 32'h0);
    tick(); $display("stall redirect pc=%h instr=%h", pc_o, instr_o);
    check_out("sr2", 1'b1, 10'h020, 32'hA000_0008);

    // Wrap-around from the last word
    redirect_i = 1'b1; redirect_pc_i = 10'h3FC;
    tick(); redirect_i = 1'b0;
    check_addr("w0", 10'h3FC);
    tick(); check_addr("w1", 10'h000);
    check_out("w1", 1'b0, 10'h000, 32'h0);
    tick(); check_out("w2", 1'b1, 10'h3FC, 32'hA000_00FF);
    tick(); check_out("w3", 1'b1, 10'h000, 32'hA000_0000);
    tick(); check_out("w4", 1'b1, 10'h004, 32'hA000_0001);

    // Back-to-back redirects: the second one wins
    redirect_i = 1'b1; redirect_pc_i = 10'h050;
    tick(); redirect_pc_i = 10'h066;
    tick(); redirect_i = 1'b0;
    check_out("bb0", 1'b0, 10'h000, 32'h0);
    check_addr("bb0", 10'h064);
    tick(); tick();
    $display("back-to-back pc=%h instr=%h", pc_o, instr_o);
    check_out("bb2", 1'b1, 10'h064, 32'hA000_0019);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch initiator that drives the synchronous instruction ROM (address in, data out one clock later, byte address with word index taken from bits [ADDR_WIDTH-1:2]).
- Generates sequential word-aligned PCs, tracks the single in-flight ROM read and buffers returned words in a small FIFO.
- Presents {pc, instr} to decode over a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes buffered and in-flight fetches.

Parameters:
- ADDR_WIDTH, 10, byte-address width shared with the ROM; PC wraps modulo 2**ADDR_WIDTH.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 0, first fetch address; must be a multiple of 4.
- FIFO_DEPTH, 2, entries in the output buffer; minimum 2 for full throughput.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- imem_addr_o  output  ADDR_WIDTH  byte address to the ROM; bits [1:0] always 0.
- imem_rdata_i  input  DATA_WIDTH  ROM read data; valid the cycle after the address is sampled.
- redirect_i  input  1  flush and restart fetch at redirect_pc_i.
- redirect_pc_i  input  ADDR_WIDTH  new PC; bits [1:0] ignored and treated as 0.
- valid_o  output  1  instr_o/pc_o hold a fetched instruction.
- ready_i  input  1  decode accepts the instruction; transfer occurs when valid_o && ready_i.
- instr_o  output  DATA_WIDTH  instruction word at the FIFO head.
- pc_o  output  ADDR_WIDTH  byte address of instr_o.

Behaviour:
- Reset (asynchronous, immediate):
  - fetch_pc = RESET_PC, so imem_addr_o = RESET_PC.
  - FIFO empty, so valid_o = 0; instr_o = 0 and pc_o = 0 while empty.
  - inflight = 0; issue permitted from the first edge.
- ROM model: the ROM samples imem_addr_o every edge and has no enable. Data arriving after a non-issue edge is ignored, because inflight = 0 for that cycle.
- Issue rule, evaluated each cycle:
  - issue = !redirect_i && (count - pop + inflight) < FIFO_DEPTH, where pop = valid_o && ready_i.
  - On an issue edge: inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (modulo 2**ADDR_WIDTH; 2**ADDR_WIDTH-4 wraps to 0).
  - On a non-issue edge: inflight <= 0 and fetch_pc holds.
- Response capture: if inflight = 1 and there is no redirect, the edge pushes {inflight_pc, imem_rdata_i} into the FIFO. The credit rule guarantees the FIFO never overflows.
- Latency: with E0 the first edge after rst_ni rises:
  - the ROM samples RESET_PC at E0;
  - the word is pushed at E1;
  - valid_o rises after E1, i.e. 2 cycles of fetch latency.
- Throughput: with ready_i held high, one instruction per cycle after the initial latency.
- Backpressure: when ready_i = 0, valid_o, instr_o and pc_o hold stable until accepted. Issue stops once the FIFO plus in-flight count reaches FIFO_DEPTH. No instruction is lost or duplicated.
- Redirect (highest priority, on the edge where redirect_i = 1):
  - FIFO flushed, inflight <= 0, so the in-flight response is discarded.
  - fetch_pc <= {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00}.
  - An instruction handshaken in the same cycle counts as consumed.
  - The first redirected instruction shows valid_o 2 cycles after the redirect edge, with no issue on the redirect edge itself.
  - Back-to-back redirects: the last one wins.
- FIFO: circular buffer with read/write pointers and count. Simultaneous push and pop with count = FIFO_DEPTH cannot occur; push and pop when empty is not bypassed, so the pushed entry appears next cycle.
- Reset mid-operation: all state cleared asynchronously, valid_o drops immediately, and fetch restarts at RESET_PC after release.

Decomposition:
- fetch_pkg contains:
  - INSTR_BYTES = 4;
  - typedef fetch_entry_t packed struct {pc, instr}, parameterised through localparams matching ADDR_WIDTH/DATA_WIDTH defaults;
  - function next_pc().
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty and full.
  - Asynchronous active-low reset.
  - Flush has priority over push and pop.

Test Plan:
- Reset then stream: ROM word i = 32'hA000_0000+i, ready_i = 1, release reset.
  - imem_addr_o = 0, 4, 8…
  - valid_o rises after the second edge, then pc_o = 0, 4, 8 with instr_o = A0000000, A0000001, A0000002 on consecutive cycles.
- Backpressure: ready_i = 0 for 5 cycles after the first valid.
  - pc_o = 0 holds and imem_addr_o stops advancing after 2 buffered entries.
  - On ready_i = 1: pc_o = 0, 4, 8 are delivered with no gaps, skips or duplicates.
- Redirect with in-flight read: while streaming at pc 8, pulse redirect_i with redirect_pc_i = 10'h103.
  - The next accepted instruction has pc_o = 10'h100 and instr_o = A0000040.
  - Words for pc 12/16 never appear.
- Redirect during stall: FIFO full with ready_i = 0, redirect to 0x20.
  - valid_o drops the next cycle and returns 2 cycles later with pc_o = 0x20.
- Wrap-around: redirect to 0x3FC with ADDR_WIDTH = 10.
  - Delivered pc_o sequence is 0x3FC, 0x000, 0x004.
- Reset mid-operation: assert rst_ni low asynchronously between edges while streaming.
  - valid_o = 0 and imem_addr_o = RESET_PC immediately.
  - After release, the sequence restarts from pc 0.
